sdc_reader_blockseq: RTL and testbench
======================================

# sdc_reader_blockseq

Read-side block sequencer for the SD card path. On a start pulse it requests consecutive blocks from the SD card core beginning at a given block address, counts the incoming bytes of each block, and buffers them in a small FIFO toward the downstream consumer with a valid/ready handshake. It is the counterpart of the writer-side address counter: it walks block addresses upward and tracks bytes per block, but for data flowing out of the card.

## Interface

- BLOCK_BYTES, 512, bytes per SD block; power of two, at least 2.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, at least 2.
- clk  in  1  system clock; all logic is on the rising edge.
- resetCounter  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a transfer; ignored while busy=1.
- startAddr  in  32  first block address, sampled on start.
- numBlocks  in  16  number of blocks to read, sampled on start.
- rdReq  out  1  read-block request to the SD core; held high until rdAck.
- rdAddr  out  32  block address for the current request; stable while rdReq=1.
- rdAck  in  1  SD core accepted the request.
- rdByteValid  in  1  one data byte from the card this cycle; the card cannot be stalled.
- rdByte  in  8  data byte.
- outValid  out  1  outByte holds valid data.
- outByte  out  8  FIFO head byte.
- outReady  in  1  consumer accepts the byte when outValid=1.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the transfer completes and the FIFO has drained.
- err  out  1  sticky error flag; cleared by start or reset.

## Operation

- States: IDLE, REQ, DATA, NEXT, DRAIN.
- IDLE: on start, latch the address into addrReg and numBlocks into blocksLeft, clear err, and go to REQ. If numBlocks=0, go to DRAIN instead.
- REQ: rdReq=1 and rdAddr=addrReg. On rdAck, go to DATA with byteCnt=0.
- DATA: each rdByteValid pushes rdByte into the FIFO and increments byteCnt (width $clog2(BLOCK_BYTES)). The valid byte with byteCnt=BLOCK_BYTES-1 moves to NEXT.
- NEXT (one cycle): addrReg += 1, with modulo-2^32 wrap and no error. blocksLeft -= 1. If the new blocksLeft is 0, go to DRAIN; otherwise go to REQ.
- DRAIN: wait for the FIFO to be empty, then pulse done for one cycle and return to IDLE.
- FIFO push and pop in the same cycle are both performed. This holds when full, since the pop frees a slot, and when empty, since the byte is written and outValid rises the next cycle.
- Overflow: a push while full with no pop drops the byte and sets err. byteCnt still advances, so block framing is preserved.
- rdByteValid outside DATA: the byte is ignored and err is set.
- rdAck outside REQ is ignored.
- Reset mid-transfer: the next cycle is IDLE, the FIFO is flushed, and rdReq drops. The in-flight card block is abandoned.

## Timing

- Reset values: rdReq=0, rdAddr=0, outValid=0, outByte=0, busy=0, done=0, err=0. Internal counters are 0.
- start sampled at edge N: busy=1 and rdReq=1 with rdAddr=startAddr after edge N.
- rdAck sampled at edge M: rdReq=0 after edge M.
- Last byte of block k at edge P: NEXT occupies the cycle after P. rdReq for block k+1 is high after edge P+1 with rdAddr=startAddr+k+1.
- FIFO latency: a byte pushed at edge Q into an empty FIFO appears on outValid/outByte after edge Q. It is registered, first-word-fall-through.
- done: asserted in the cycle after the FIFO becomes empty in DRAIN. busy falls together with done.
- A start pulse in the same cycle as done is ignored.

## Structure

- Shared package holds:
  - state encoding constants (IDLE/REQ/DATA/NEXT/DRAIN);
  - SDC_ADDR_W=32 and SDC_BLOCK_BYTES=512, also used by the writer side.
- One sub-module: sdc_byte_fifo. It is a synchronous FIFO parameterised by depth, with push, pop, full, empty and a registered head output.
- The FSM, byteCnt, blocksLeft and addrReg live in the top module.

## Test plan

- startAddr=0x100, numBlocks=2, outReady=1, 512 bytes per block with rdAck after 3 cycles -> requests go out at 0x100 then 0x101. 1024 bytes leave in order, done pulses once, err=0.
- startAddr=0xFFFFFFFF, numBlocks=2 -> the second rdAddr is 0x00000000 and err=0.
- outReady=0 for an entire block with FIFO_DEPTH=16 -> the first 16 bytes are held, the rest are dropped, and err=1. done still pulses once outReady returns and the FIFO drains.
- numBlocks=0 -> rdReq never rises, and done pulses 2 cycles after start.
- resetCounter asserted mid-block (byte 200) -> outputs are at reset values the next cycle. A fresh start then reads correctly.
- rdByteValid in IDLE and a start pulse while busy -> err=1 for the stray byte, and the second start is ignored (rdAddr unchanged).

Source files
------------

// File: rtl/sdc_reader_blockseq_pkg.sv
// Shared definitions for the SD card block sequencers (reader and writer side).
package sdc_reader_blockseq_pkg;

    localparam int SDC_ADDR_W      = 32;
    localparam int SDC_BLOCK_BYTES = 512;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_DATA  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/sdc_reader_blockseq_byte_fifo.sv
// Synchronous byte FIFO with a registered first-word-fall-through head.
module sdc_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after_pop;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_next;
    logic             push_ok;
    logic             pop_ok;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    always_comb begin
        full            = (count == CNT_W'(DEPTH));
        empty           = (count == '0);
        pop_ok          = pop && !empty;
        push_ok         = push && (!full || pop_ok);
        overflow        = push && full && !pop_ok;
        rd_next         = rd_ptr + PTR_W'(pop_ok);
        count_after_pop = count - CNT_W'(pop_ok);
        count_next      = count_after_pop + CNT_W'(push_ok);
        head_next       = head_q;
        if (count_after_pop != '0) begin
            head_next = mem[rd_next];
        end else if (push_ok) begin
            head_next = din;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_ptr + PTR_W'(push_ok);
            count  <= count_next;
            head_q <= head_next;
        end
    end

    assign head = head_q;

endmodule

// File: rtl/sdc_reader_blockseq.sv
// Read-side block sequencer: requests consecutive SD blocks, frames their bytes
// and buffers them through a byte FIFO toward a valid/ready consumer.
module sdc_reader_blockseq
    import sdc_reader_blockseq_pkg::*;
#(
    parameter int BLOCK_BYTES = SDC_BLOCK_BYTES,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetCounter,
    input  logic                  start,
    input  logic [SDC_ADDR_W-1:0] startAddr,
    input  logic [15:0]           numBlocks,
    output logic                  rdReq,
    output logic [SDC_ADDR_W-1:0] rdAddr,
    input  logic                  rdAck,
    input  logic                  rdByteValid,
    input  logic [7:0]            rdByte,
    output logic                  outValid,
    output logic [7:0]            outByte,
    input  logic                  outReady,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int                CNT_W     = $clog2(BLOCK_BYTES);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);

    state_t                  state;
    state_t                  state_next;
    logic [SDC_ADDR_W-1:0]   addr_reg;
    logic [15:0]             blocks_left;
    logic [CNT_W-1:0]        byte_cnt;
    logic                    done_q;
    logic                    err_q;
    logic                    start_ok;
    logic                    in_data;
    logic                    byte_push;
    logic                    last_byte;
    logic                    stray_byte;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_overflow;
    logic [7:0]              fifo_head;

    // A start coinciding with the done pulse is dropped so back-to-back transfers stay distinct.
    always_comb begin
        start_ok   = (state == ST_IDLE) && start && !done_q;
        in_data    = (state == ST_DATA);
        byte_push  = in_data && rdByteValid;
        last_byte  = byte_push && (byte_cnt == LAST_BYTE);
        stray_byte = rdByteValid && !in_data;
    end

    always_ff @(posedge clk) begin
        if (resetCounter) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = (numBlocks == 16'd0) ? ST_DRAIN : ST_REQ;
                end
            end
            ST_REQ: begin
                if (rdAck) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_byte) begin
                    state_next = ST_NEXT;
                end
            end
            ST_NEXT: begin
                state_next = (blocks_left == 16'd1) ? ST_DRAIN : ST_REQ;
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rdReq    = (state == ST_REQ);
        rdAddr   = addr_reg;
        busy     = (state != ST_IDLE);
        done     = done_q;
        err      = err_q;
        outValid = !fifo_empty;
        outByte  = fifo_head;
    end

    // Dropped bytes still advance byte_cnt so the card's block framing is never lost.
    always_ff @(posedge clk) begin
        if (resetCounter) begin
            addr_reg    <= '0;
            blocks_left <= '0;
            byte_cnt    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (start_ok) begin
                addr_reg    <= startAddr;
                blocks_left <= numBlocks;
            end
            if ((state == ST_REQ) && rdAck) begin
                byte_cnt <= '0;
            end else if (byte_push) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
            end
            if (state == ST_NEXT) begin
                addr_reg    <= addr_reg + SDC_ADDR_W'(1);
                blocks_left <= blocks_left - 16'd1;
            end
            done_q <= (state == ST_DRAIN) && fifo_empty;
            if (stray_byte || fifo_overflow) begin
                err_q <= 1'b1;
            end else if (start_ok) begin
                err_q <= 1'b0;
            end
        end
    end

    sdc_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .reset    (resetCounter),
        .push     (byte_push),
        .din      (rdByte),
        .pop      (outReady),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_overflow)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_sdc_reader_blockseq.sv
// Randomised bench for sdc_reader_blockseq against a queue-based FIFO and
// transaction-level sequencing model.
module tb_sdc_reader_blockseq;

    localparam int BB    = 512;
    localparam int DEPTH = 16;

    logic        clk;
    logic        resetCounter;
    logic        start;
    logic [31:0] startAddr;
    logic [15:0] numBlocks;
    logic        rdReq;
    logic [31:0] rdAddr;
    logic        rdAck;
    logic        rdByteValid;
    logic [7:0]  rdByte;
    logic        outValid;
    logic [7:0]  outByte;
    logic        outReady;
    logic        busy;
    logic        done;
    logic        err;

    logic [7:0]  mq[$];
    bit          errExp;
    bit          inData;
    bit          inDrain;
    int          readyMode;
    int          popCnt;
    int          testsRun;
    int          testsFailed;

    sdc_reader_blockseq #(
        .BLOCK_BYTES (BB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .resetCounter (resetCounter),
        .start        (start),
        .startAddr    (startAddr),
        .numBlocks    (numBlocks),
        .rdReq        (rdReq),
        .rdAddr       (rdAddr),
        .rdAck        (rdAck),
        .rdByteValid  (rdByteValid),
        .rdByte       (rdByte),
        .outValid     (outValid),
        .outByte      (outByte),
        .outReady     (outReady),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic setReady();
        case (readyMode)
            0:       outReady = 1'b1;
            1:       outReady = ($urandom_range(0, 3) != 0);
            default: outReady = inDrain;
        endcase
    endtask

    // Advance one clock: update the reference FIFO from the inputs about to be sampled,
    // then compare the DUT just after the edge.
    task automatic tick(input bit eReq, input logic [31:0] eAddr, input bit eBusy, input bit eDone);
        bit pop;
        bit push;
        pop = (mq.size() > 0) && outReady;
        if (resetCounter) begin
            mq.delete();
            errExp = 1'b0;
        end else begin
            push = rdByteValid && inData;
            if (rdByteValid && !inData) errExp = 1'b1;
            if (push && mq.size() == DEPTH && !pop) begin
                errExp = 1'b1;
                push = 1'b0;
            end
            if (pop) begin
                void'(mq.pop_front());
                popCnt++;
            end
            if (push) mq.push_back(rdByte);
        end
        @(posedge clk);
        #1;
        checkOutput("rdReq", rdReq, eReq);
        if (eReq) checkOutput("rdAddr", rdAddr, eAddr);
        checkOutput("busy", busy, eBusy);
        checkOutput("done", done, eDone);
        checkOutput("outValid", outValid, mq.size() > 0);
        if (mq.size() > 0) checkOutput("outByte", outByte, mq[0]);
        checkOutput("err", err, errExp);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input int nblk, input int mode,
                                 input int ackDly, input bit strayStart, input int abortAt);
        logic [31:0] cur;
        int sent;
        int guard;
        int dly;
        bit empty;
        readyMode = mode;
        inDrain   = 1'b0;
        popCnt    = 0;
        cur       = addr;
        start     = 1'b1;
        startAddr = addr;
        numBlocks = 16'(nblk);
        errExp    = 1'b0;
        setReady();
        tick(nblk != 0, addr, 1'b1, 1'b0);
        start     = 1'b0;
        startAddr = $urandom;
        numBlocks = 16'($urandom);
        for (int b = 0; b < nblk; b++) begin
            dly = (ackDly < 0) ? $urandom_range(0, 4) : ackDly;
            for (int d = 0; d < dly; d++) begin
                start = strayStart && (b == 0) && (d == 0);
                setReady();
                tick(1'b1, cur, 1'b1, 1'b0);
                start = 1'b0;
            end
            rdAck = 1'b1;
            setReady();
            tick(1'b0, cur, 1'b1, 1'b0);
            rdAck  = 1'b0;
            inData = 1'b1;
            sent   = 0;
            while (sent < BB) begin
                if (abortAt >= 0 && sent == abortAt) begin
                    rdByteValid  = 1'b0;
                    resetCounter = 1'b1;
                    inData       = 1'b0;
                    setReady();
                    tick(1'b0, 32'h0, 1'b0, 1'b0);
                    checkOutput("rstAddr", rdAddr, 32'h0);
                    checkOutput("rstByte", outByte, 32'h0);
                    resetCounter = 1'b0;
                    return;
                end
                rdByteValid = ($urandom_range(0, 3) != 0) || (abortAt >= 0);
                rdByte      = 8'($urandom);
                if (rdByteValid) sent++;
                setReady();
                tick(1'b0, cur, 1'b1, 1'b0);
            end
            rdByteValid = 1'b0;
            inData      = 1'b0;
            cur         = cur + 32'd1;
            setReady();
            tick(b < nblk - 1, cur, 1'b1, 1'b0);
        end
        inDrain = 1'b1;
        guard   = 0;
        empty   = 1'b0;
        while (!empty && guard < 3000) begin
            setReady();
            empty = (mq.size() == 0);
            tick(1'b0, cur, !empty, empty);
            guard++;
        end
        if (!empty) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drainTimeout: FIFO model still holds %0d bytes, expected 0", mq.size());
        end
        inDrain = 1'b0;
        tick(1'b0, cur, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun     = 0;
        testsFailed  = 0;
        resetCounter = 1'b1;
        start        = 1'b0;
        startAddr    = '0;
        numBlocks    = '0;
        rdAck        = 1'b0;
        rdByteValid  = 1'b0;
        rdByte       = '0;
        outReady     = 1'b1;
        readyMode    = 0;
        inData       = 1'b0;
        inDrain      = 1'b0;
        errExp       = 1'b0;
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("resetAddr", rdAddr, 32'h0);
        checkOutput("resetByte", outByte, 32'h0);
        resetCounter = 1'b0;

        applyStimulus(32'h0000_0100, 2, 0, 3, 1'b0, -1);
        checkOutput("basicCount", popCnt, 1024);
        checkOutput("basicErr", err, 32'h0);

        applyStimulus(32'hFFFF_FFFF, 2, 0, -1, 1'b0, -1);
        checkOutput("wrapErr", err, 32'h0);

        applyStimulus(32'h0000_2000, 1, 2, 2, 1'b0, -1);
        checkOutput("ovfCount", popCnt, DEPTH);
        checkOutput("ovfErr", err, 32'h1);

        applyStimulus(32'h0000_0055, 0, 0, 0, 1'b0, -1);
        checkOutput("zeroErr", err, 32'h0);

        applyStimulus(32'h0000_0300, 2, 0, 1, 1'b0, 200);
        applyStimulus(32'h0000_0301, 1, 0, -1, 1'b0, -1);
        checkOutput("afterRstCount", popCnt, BB);

        rdByteValid = 1'b1;
        rdByte      = 8'hA5;
        inData      = 1'b0;
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        rdByteValid = 1'b0;
        checkOutput("strayErr", err, 32'h1);
        applyStimulus(32'h0000_0400, 1, 1, 2, 1'b1, -1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus($urandom, $urandom_range(0, 2), $urandom_range(0, 1), -1,
                          1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
